seg_shift_ctrl: RTL

Serial refresh controller for the 8-digit seven-segment display. It takes the 64-bit segment pattern produced by HexTo8SEG (`SEG_TXT`) and shifts it MSB-first into the board's external serial-in/parallel-out shift-register chain. It generates the serial clock, data and latch strobes, and reports completion through a busy/done handshake. It sits between HexTo8SEG and the top-level display pins, and is the only block that drives those pins.

---
 rtl/seg_ctrl_pkg.sv | 14 +
 rtl/seg_bit_timer.sv | 32 +++
 rtl/seg_shift_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared types and defaults for the seven-segment serial refresh controller.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } seg_state_t;

  localparam int SEG_DATA_W      = 64;
  localparam int SEG_CLK_DIV_DEF = 2;

endpackage

// File: rtl/seg_bit_timer.sv
// Bit-period divider: counts 0..2*CLK_DIV-1 and flags the s_clk rise and fall points.
module seg_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(2 * CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == FALL_AT) ? '0 : div_cnt + 1'b1;
    end
  end

  assign rise_tick = en && (div_cnt == RISE_AT);
  assign fall_tick = en && (div_cnt == FALL_AT);

endmodule

// File: rtl/seg_shift_ctrl.sv
// Shifts a DATA_W-bit segment pattern MSB-first into the external SIPO chain, then latches it.
// Optional periodic refresh is built when SEG_AUTO_REFRESH_EN is defined.
module seg_shift_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int DATA_W      = SEG_DATA_W,
  parameter int CLK_DIV     = SEG_CLK_DIV_DEF,
  parameter int REFRESH_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_lat
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  if (CLK_DIV < 1 || DATA_W < 3 || REFRESH_CYC < 2) begin : g_bad_param
    $error("seg_shift_ctrl: illegal parameter value");
  end

  seg_state_t       state;
  logic [BIT_W-1:0] bit_cnt;
  // Holds only the bits not yet presented on s_dat; the MSB goes straight to s_dat on capture.
  logic [DATA_W-2:0] sreg;
  logic             go;
  logic             rise_tick;
  logic             fall_tick;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYC);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYC - 1);

  logic [REF_W-1:0] ref_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
    end
  end

  // A wrap that lands outside IDLE is simply dropped.
  assign go = start | ((ref_cnt == REF_LAST) && (state == IDLE));
`else
  assign go = start;
`endif

  seg_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .en        ((state == SHIFT) || (state == LATCH)),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && go) begin
      sreg <= par_data[DATA_W-2:0];
    end else if (state == SHIFT && fall_tick) begin
      sreg <= {sreg[DATA_W-3:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_dat   <= 1'b0;
      s_lat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            busy    <= 1'b1;
            s_clk   <= 1'b0;
            s_dat   <= par_data[DATA_W-1];
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            s_clk <= 1'b1;
          end
          if (fall_tick) begin
            s_clk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              s_lat <= 1'b1;
              state <= LATCH;
            end else begin
              s_dat   <= sreg[DATA_W-2];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        LATCH: begin
          // The timer restarted at 0 on entry, so its rise point marks CLK_DIV cycles of latch.
          if (rise_tick) begin
            s_lat <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          s_clk <= 1'b0;
          s_lat <= 1'b0;
        end
      endcase
    end
  end

endmodule
